muxn_reg_arb: RTL and testbench

- CH-input, N-bit registered multiplexer with valid/ready handshakes on every input channel and on the output.
- Generalises the plain 2:1 combinational data select used across the datapath. Adds channel count, an output pipeline register, backpressure, and a runtime-selectable round-robin arbitration mode.
- Sits between operand/result sources and the ALU/register-file write port of the calculator processor.

---
 rtl/muxn_reg_arb_pkg.sv | 16 +
 rtl/muxn_reg_arb_rr_arbiter.sv | 37 +++
 rtl/muxn_reg_arb.sv | 118 +++++++++++
 tb/tb_muxn_reg_arb.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/muxn_reg_arb_pkg.sv
// Purpose: shared encodings and helpers for the registered N-bit, CH-channel mux/arbiter.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Contents: mode encodings and the packed-bus slice helper used to address channel i
//           of a CH*N packed bus as bits [chan_lsb(i, N) +: N].
package muxn_reg_arb_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // LSB position of channel idx inside a packed bus of width-bit channels.
  function automatic int chan_lsb(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/muxn_reg_arb_rr_arbiter.sv
// Purpose: round-robin request picker; first set request scanning ptr, ptr+1, ... mod CH.
// Latency: purely combinational, no state.
// Backpressure: none here; the caller qualifies the grant with its own load enable.
// Ports: req[CH-1:0] requests, ptr[SW-1:0] highest-priority index (must be < CH),
//        gnt_valid any request found, gnt_idx[SW-1:0] chosen channel.
module rr_arbiter #(
  parameter int CH = 4,
  parameter int SW = 2
) (
  input  logic [CH-1:0] req,
  input  logic [SW-1:0] ptr,
  output logic          gnt_valid,
  output logic [SW-1:0] gnt_idx
);

  // One spare bit so ptr + k can exceed CH-1 before the wrap subtraction.
  logic [SW:0] pos;

  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    pos       = '0;
    // Walk from the farthest offset back to ptr so the closest hit wins by being last.
    for (int k = CH - 1; k >= 0; k--) begin
      pos = {1'b0, ptr} + (SW + 1)'(k);
      // ptr < CH and k < CH, so one subtraction is enough to wrap.
      if (pos >= (SW + 1)'(CH)) begin
        pos = pos - (SW + 1)'(CH);
      end
      if (req[pos[SW-1:0]]) begin
        gnt_valid = 1'b1;
        gnt_idx   = pos[SW-1:0];
      end
    end
  end

endmodule

// File: rtl/muxn_reg_arb.sv
// Purpose: CH-input N-bit mux with valid/ready per channel, fixed-select or round-robin grant,
//          and a single output pipeline register.
// Latency: exactly 1 cycle from input transfer to valid_out; full throughput with ready_out high.
// Backpressure: ready_in only to the granted channel and only when the output register can load
//               (empty or draining this cycle); held word stays stable while ready_out is low.
// Ports: clk/rst (async active-high), data_in[CH*N] packed channels, valid_in/ready_in[CH],
//        mode (0 fixed via sel, 1 round-robin), sel[SW], data_out[N], chan_out[SW],
//        valid_out, ready_out.
module muxn_reg_arb
  import muxn_reg_arb_pkg::*;
#(
  parameter  int N  = 16,
  parameter  int CH = 4,
  localparam int SW = $clog2(CH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [CH*N-1:0] data_in,
  input  logic [CH-1:0]   valid_in,
  output logic [CH-1:0]   ready_in,
  input  logic            mode,
  input  logic [SW-1:0]   sel,
  output logic [N-1:0]    data_out,
  output logic [SW-1:0]   chan_out,
  output logic            valid_out,
  input  logic            ready_out
);

  logic [N-1:0]  data_out_q, data_out_d;
  logic [SW-1:0] chan_out_q, chan_out_d;
  logic          valid_out_q, valid_out_d;
  logic [SW-1:0] rr_ptr_q, rr_ptr_d;

  logic          rr_gnt_vld;
  logic [SW-1:0] rr_gnt_idx;
  logic          fix_gnt_vld;
  logic          grant_vld;
  logic [SW-1:0] grant_idx;
  logic [N-1:0]  grant_data;
  logic          load;
  logic          xfer;

  rr_arbiter #(
    .CH (CH),
    .SW (SW)
  ) u_rr_arbiter (
    .req       (valid_in),
    .ptr       (rr_ptr_q),
    .gnt_valid (rr_gnt_vld),
    .gnt_idx   (rr_gnt_idx)
  );

  // Fixed-select decode: an out-of-range sel (possible when CH is not a power of two)
  // matches no channel and therefore grants nothing.
  always_comb begin
    fix_gnt_vld = 1'b0;
    for (int i = 0; i < CH; i++) begin
      if (sel == SW'(i) && valid_in[i]) begin
        fix_gnt_vld = 1'b1;
      end
    end
  end

  always_comb begin
    grant_vld = (mode == MODE_RR) ? rr_gnt_vld : fix_gnt_vld;
    grant_idx = (mode == MODE_RR) ? rr_gnt_idx : sel;
    load      = !valid_out_q || ready_out;
    xfer      = load && grant_vld;
  end

  always_comb begin
    grant_data = '0;
    ready_in   = '0;
    for (int i = 0; i < CH; i++) begin
      if (grant_idx == SW'(i)) begin
        grant_data = data_in[chan_lsb(i, N) +: N];
        ready_in[i] = xfer && !rst;
      end
    end
  end

  always_comb begin
    data_out_d  = data_out_q;
    chan_out_d  = chan_out_q;
    valid_out_d = valid_out_q;
    rr_ptr_d    = rr_ptr_q;
    if (load) begin
      // With no grant the register drains; data/chan keep their last values.
      valid_out_d = grant_vld;
      if (grant_vld) begin
        data_out_d = grant_data;
        chan_out_d = grant_idx;
      end
    end
    if (xfer && mode == MODE_RR) begin
      rr_ptr_d = (grant_idx == SW'(CH - 1)) ? '0 : grant_idx + SW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out_q  <= '0;
      chan_out_q  <= '0;
      valid_out_q <= 1'b0;
      rr_ptr_q    <= '0;
    end else begin
      data_out_q  <= data_out_d;
      chan_out_q  <= chan_out_d;
      valid_out_q <= valid_out_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign data_out  = data_out_q;
  assign chan_out  = chan_out_q;
  assign valid_out = valid_out_q;

endmodule

// File: tb/tb_muxn_reg_arb.sv
// Purpose: self-checking bench for muxn_reg_arb (N=16, CH=4) with a reference model and scoreboard.
// Latency: model expects each accepted word at the output one cycle after its transfer.
// Backpressure: randomised and directed ready_out stalls; words are checked when consumed.
module tb_muxn_reg_arb;

  localparam int N  = 16;
  localparam int CH = 4;

  typedef struct packed {
    logic [N-1:0] d;
    logic [1:0]   c;
  } exp_t;

  logic            clk;
  logic            rst;
  logic [CH*N-1:0] data_in;
  logic [CH-1:0]   valid_in;
  logic [CH-1:0]   ready_in;
  logic            mode;
  logic [1:0]      sel;
  logic [N-1:0]    data_out;
  logic [1:0]      chan_out;
  logic            valid_out;
  logic            ready_out;

  int   tests;
  int   fails;
  exp_t sb[$];
  bit   m_vld;
  int   m_rr;

  muxn_reg_arb #(.N(N), .CH(CH)) dut (
    .clk       (clk),
    .rst       (rst),
    .data_in   (data_in),
    .valid_in  (valid_in),
    .ready_in  (ready_in),
    .mode      (mode),
    .sel       (sel),
    .data_out  (data_out),
    .chan_out  (chan_out),
    .valid_out (valid_out),
    .ready_out (ready_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Grant from the rules: fixed -> sel if in range and valid; round-robin -> first valid
  // channel scanning from the pointer with modulo wrap. Returns -1 when nothing is granted.
  function automatic int model_grant(input int md, input int sl, input logic [CH-1:0] v, input int ptr);
    if (md == 0) begin
      if (sl < CH && ((v >> sl) & 4'd1) != 4'd0) return sl;
      return -1;
    end
    for (int k = 0; k < CH; k++) begin
      int c;
      c = (ptr + k) % CH;
      if (((v >> c) & 4'd1) != 4'd0) return c;
    end
    return -1;
  endfunction

  // Called once per cycle after inputs settle, before the rising edge.
  task automatic step_model();
    int   g;
    bit   load_m;
    logic [CH-1:0] exp_rdy;
    exp_t e;
    g      = model_grant(int'(mode), int'(sel), valid_in, m_rr);
    load_m = !m_vld || ready_out;
    exp_rdy = (load_m && g >= 0) ? 4'(1 << g) : 4'd0;
    chk("ready_in", 32'(ready_in), 32'(exp_rdy));
    chk("valid_out", 32'(valid_out), 32'(m_vld));
    if (load_m) begin
      if (g >= 0) begin
        e.d = data_in[g*N +: N];
        e.c = 2'(g);
        sb.push_back(e);
        if (mode) m_rr = (g + 1) % CH;
      end
      m_vld = (g >= 0);
    end
  endtask

  // md/sl/vfix < 0 mean random; dpat 0 random data, 1 ch i = 0x0010+i, 2 ch2 = A5A5.
  task automatic phase(input int cyc, input int md, input int sl, input int vfix,
                       input int dpat, input int rdy_pct);
    for (int n = 0; n < cyc; n++) begin
      @(negedge clk);
      mode     = (md < 0) ? 1'($urandom_range(0, 1)) : 1'(md);
      sel      = (sl < 0) ? 2'($urandom_range(0, 3)) : 2'(sl);
      valid_in = (vfix < 0) ? 4'($urandom) : 4'(vfix);
      for (int i = 0; i < CH; i++) begin
        if (dpat == 1)                data_in[i*N +: N] = 16'h0010 + 16'(i);
        else if (dpat == 2 && i == 2) data_in[i*N +: N] = 16'hA5A5;
        else                          data_in[i*N +: N] = 16'($urandom);
      end
      ready_out = (int'($urandom_range(0, 99)) < rdy_pct);
      #1;
      step_model();
    end
  endtask

  // Monitor: a word leaves the output register at the edge where valid_out & ready_out.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst && valid_out === 1'b1 && ready_out === 1'b1) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL sb_unexpected: output word %0h ch %0d with nothing expected", data_out, chan_out);
        end else begin
          e = sb.pop_front();
          chk("data_out", 32'(data_out), 32'(e.d));
          chk("chan_out", 32'(chan_out), 32'(e.c));
        end
      end
    end
  end

  initial begin
    tests     = 0;
    fails     = 0;
    m_vld     = 1'b0;
    m_rr      = 0;
    rst       = 1'b1;
    mode      = 1'b0;
    sel       = 2'd0;
    valid_in  = 4'hF;
    ready_out = 1'b1;
    data_in   = '1;
    #1;
    chk("rst_ready_in", 32'(ready_in), 32'd0);
    chk("rst_valid_out", 32'(valid_out), 32'd0);
    chk("rst_data_out", 32'(data_out), 32'd0);
    chk("rst_chan_out", 32'(chan_out), 32'd0);
    @(negedge clk);
    valid_in = 4'h0;
    rst      = 1'b0;

    phase(3, 0, 2, 15, 2, 100);   // fixed select ch2
    phase(3, 0, 3, 7, 0, 100);    // sel on an idle channel: drain, no grant
    phase(5, 1, 0, 15, 1, 100);   // round-robin 0,1,2,3,0 back to back
    phase(2, 1, 0, 9, 1, 100);    // sparse 1001 from ptr 1: ch3 then ch0
    phase(3, 1, 0, 15, 1, 0);     // stall with a held word
    phase(3, 1, 0, 15, 1, 100);   // release: drain and refill together
    phase(1500, -1, -1, -1, 0, 70);

    // Mid-cycle reset with a word held in the output register.
    @(negedge clk);
    mode = 1'b0; sel = 2'd1; valid_in = 4'b0010; ready_out = 1'b1;
    data_in[1*N +: N] = 16'h1234;
    #1;
    step_model();
    @(negedge clk);
    valid_in = 4'h0; ready_out = 1'b0;
    #1;
    step_model();
    #2;
    rst = 1'b1; valid_in = 4'hF; ready_out = 1'b1;
    #1;
    chk("mid_rst_valid_out", 32'(valid_out), 32'd0);
    chk("mid_rst_data_out", 32'(data_out), 32'd0);
    chk("mid_rst_chan_out", 32'(chan_out), 32'd0);
    chk("mid_rst_ready_in", 32'(ready_in), 32'd0);
    sb.delete();
    m_vld = 1'b0;
    m_rr  = 0;
    @(negedge clk);
    chk("rst_hold_valid_out", 32'(valid_out), 32'd0);
    valid_in = 4'h0;
    rst = 1'b0;

    phase(2, 1, 0, 15, 1, 100);   // pointer restarted at 0
    phase(2, 0, 0, 0, 0, 100);    // drain everything
    #3;
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
